// File: rtl/dsm_pipelined_accumulator.sv
// First-order DSM accumulator (A += x mod 2^N, carry = overflow), carry chain split into SEG registered segments.
// Latency SEG enabled edges from x to aligned acc/carry; en=0 freezes the whole pipeline, clr/rst empty it.
module dsm_pipelined_accumulator #(
    parameter int N   = 16,
    parameter int SEG = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [N-1:0] x,
    output logic [N-1:0] acc,
    output logic         carry,
    output logic         valid
);
    localparam int W  = N / SEG;
    localparam int CW = $clog2(SEG + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(SEG);

    if ((SEG < 1) || (N % SEG != 0)) begin : g_bad_param
        $error("dsm_pipelined_accumulator: N must be a multiple of SEG");
    end

    // Registered carry-out of every segment; bit k feeds segment k+1 one edge later.
    logic [SEG-1:0] seg_cy;

    for (genvar k = 0; k < SEG; k++) begin : g_seg
        localparam int D = SEG - 1 - k;

        logic [W-1:0] x_in;
        logic         cy_in;
        logic [W-1:0] sum_q, sum_d;
        logic         cy_q, cy_d;

        if (k == 0) begin : g_nodly
            assign x_in  = x[W-1:0];
            assign cy_in = 1'b0;
        end else begin : g_dly
            // Slice k waits k edges so it meets the carry rippling up from below.
            logic [W-1:0] dly_q [k];
            logic [W-1:0] dly_d [k];

            always_comb begin
                for (int j = 0; j < k; j++) begin
                    dly_d[j] = dly_q[j];
                end
                if (clr) begin
                    for (int j = 0; j < k; j++) begin
                        dly_d[j] = '0;
                    end
                end else if (en) begin
                    dly_d[0] = x[k*W +: W];
                    for (int j = 1; j < k; j++) begin
                        dly_d[j] = dly_q[j-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int j = 0; j < k; j++) begin
                        dly_q[j] <= '0;
                    end
                end else begin
                    for (int j = 0; j < k; j++) begin
                        dly_q[j] <= dly_d[j];
                    end
                end
            end

            assign x_in  = dly_q[k-1];
            assign cy_in = seg_cy[k-1];
        end

        always_comb begin
            sum_d = sum_q;
            cy_d  = cy_q;
            if (clr) begin
                sum_d = '0;
                cy_d  = 1'b0;
            end else if (en) begin
                {cy_d, sum_d} = {1'b0, sum_q} + {1'b0, x_in} + {{W{1'b0}}, cy_in};
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                sum_q <= '0;
                cy_q  <= 1'b0;
            end else begin
                sum_q <= sum_d;
                cy_q  <= cy_d;
            end
        end

        assign seg_cy[k] = cy_q;

        if (D == 0) begin : g_nodsk
            assign acc[k*W +: W] = sum_q;
        end else begin : g_dsk
            // Lower slices finish early; hold them back until the MSB slice catches up.
            logic [W-1:0] dsk_q [D];
            logic [W-1:0] dsk_d [D];

            always_comb begin
                for (int j = 0; j < D; j++) begin
                    dsk_d[j] = dsk_q[j];
                end
                if (clr) begin
                    for (int j = 0; j < D; j++) begin
                        dsk_d[j] = '0;
                    end
                end else if (en) begin
                    dsk_d[0] = sum_q;
                    for (int j = 1; j < D; j++) begin
                        dsk_d[j] = dsk_q[j-1];
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int j = 0; j < D; j++) begin
                        dsk_q[j] <= '0;
                    end
                end else begin
                    for (int j = 0; j < D; j++) begin
                        dsk_q[j] <= dsk_d[j];
                    end
                end
            end

            assign acc[k*W +: W] = dsk_q[D-1];
        end
    end

    assign carry = seg_cy[SEG-1];

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign valid = (cnt_q == CNT_MAX);

endmodule

// File: tb/tb_dsm_pipelined_accumulator.sv
// Scoreboard bench: four parameterisations share one stimulus stream; a behavioural
// S(n) model pushes each result and pops it when the pipeline has filled.
module tb_dsm_pipelined_accumulator;

    logic        clk = 1'b0;
    logic        rst, en, clr;
    logic [23:0] x_all;

    logic [15:0] acc_a, acc_b;
    logic [23:0] acc_c;
    logic [7:0]  acc_d;
    logic        cy_a, cy_b, cy_c, cy_d;
    logic        vld_a, vld_b, vld_c, vld_d;

    always #5 clk = ~clk;

    dsm_pipelined_accumulator #(.N(16), .SEG(4)) u_dut (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .x(x_all[15:0]),
        .acc(acc_a), .carry(cy_a), .valid(vld_a));
    dsm_pipelined_accumulator #(.N(16), .SEG(1)) u_s1 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .x(x_all[15:0]),
        .acc(acc_b), .carry(cy_b), .valid(vld_b));
    dsm_pipelined_accumulator #(.N(24), .SEG(8)) u_s8 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .x(x_all),
        .acc(acc_c), .carry(cy_c), .valid(vld_c));
    dsm_pipelined_accumulator #(.N(8), .SEG(8)) u_n8 (
        .clk(clk), .rst(rst), .en(en), .clr(clr), .x(x_all[7:0]),
        .acc(acc_d), .carry(cy_d), .valid(vld_d));

    logic [23:0] got_acc [4];
    logic        got_cy  [4];
    logic        got_vld [4];
    assign got_acc[0] = {8'h00, acc_a};
    assign got_acc[1] = {8'h00, acc_b};
    assign got_acc[2] = acc_c;
    assign got_acc[3] = {16'h0000, acc_d};
    assign got_cy[0]  = cy_a;
    assign got_cy[1]  = cy_b;
    assign got_cy[2]  = cy_c;
    assign got_cy[3]  = cy_d;
    assign got_vld[0] = vld_a;
    assign got_vld[1] = vld_b;
    assign got_vld[2] = vld_c;
    assign got_vld[3] = vld_d;

    localparam int NI [4] = '{16, 16, 24, 8};
    localparam int SI [4] = '{4, 1, 8, 8};

    int          n_cmp = 0;
    int          n_err = 0;
    logic [23:0] model_a [4];
    int          fill    [4];
    logic [24:0] sbq     [4][$];
    logic [23:0] exp_acc [4];
    logic        exp_cy  [4];
    logic        exp_vld [4];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock edge with the given controls, then model update and output check.
    task automatic step(input logic r, input logic c, input logic e, input logic [23:0] xv);
        logic [23:0] mask;
        logic [24:0] s;
        logic [24:0] ex;
        rst   = r;
        clr   = c;
        en    = e;
        x_all = xv;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            mask = (24'h1 << NI[i]) - 24'h1;
            if (r || c) begin
                model_a[i] = '0;
                fill[i]    = 0;
                sbq[i].delete();
                exp_acc[i] = '0;
                exp_cy[i]  = 1'b0;
                exp_vld[i] = 1'b0;
            end else if (e) begin
                s = {1'b0, model_a[i]} + {1'b0, xv & mask};
                model_a[i] = s[23:0] & mask;
                sbq[i].push_back({s[NI[i]], model_a[i]});
                if (fill[i] < SI[i]) fill[i]++;
                if (fill[i] == SI[i]) begin
                    ex = sbq[i].pop_front();
                    exp_acc[i] = ex[23:0];
                    exp_cy[i]  = ex[24];
                    exp_vld[i] = 1'b1;
                end else begin
                    exp_acc[i] = '0;
                    exp_cy[i]  = 1'b0;
                    exp_vld[i] = 1'b0;
                end
            end
            chk($sformatf("acc[%0d]", i),   {8'h00, got_acc[i]}, {8'h00, exp_acc[i]});
            chk($sformatf("carry[%0d]", i), {31'h0, got_cy[i]},  {31'h0, exp_cy[i]});
            chk($sformatf("valid[%0d]", i), {31'h0, got_vld[i]}, {31'h0, exp_vld[i]});
        end
    endtask

    initial begin
        int ncarry;
        bit seen;
        rst = 1'b1; clr = 1'b0; en = 1'b0; x_all = '0;

        step(1, 0, 0, 24'h0);
        step(1, 0, 1, 24'hFFFFFF);

        // Constant increment: first result 0x1000, wrap every 16th result.
        ncarry = 0;
        for (int i = 0; i < 36; i++) begin
            step(0, 0, 1, 24'h001000);
            if (i == 3) begin
                chk("t1_first_acc", {16'h0, acc_a}, 32'h1000);
                chk("t1_first_valid", {31'h0, vld_a}, 32'h1);
            end
            if (cy_a) ncarry++;
        end
        chk("t1_carry_count", ncarry, 2);

        // Full carry ripple through every segment.
        step(0, 1, 1, 24'h0);
        step(0, 0, 1, 24'hFFFFFF);
        step(0, 0, 1, 24'h000001);
        step(0, 0, 1, 24'h0);
        step(0, 0, 1, 24'h0);
        chk("t2_r0", {15'h0, cy_a, acc_a}, {15'h0, 1'b0, 16'hFFFF});
        step(0, 0, 1, 24'h0);
        chk("t2_r1", {15'h0, cy_a, acc_a}, {15'h0, 1'b1, 16'h0000});
        step(0, 0, 1, 24'h0);
        chk("t2_r2", {15'h0, cy_a, acc_a}, {15'h0, 1'b0, 16'h0000});
        for (int i = 0; i < 4; i++) step(0, 0, 1, 24'h0);

        // Stall after the 6th edge; x during the stall must be ignored.
        step(0, 1, 0, 24'h0);
        for (int i = 0; i < 6; i++) step(0, 0, 1, 24'h001000);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 24'hABCDEF);
        for (int i = 0; i < 12; i++) step(0, 0, 1, 24'h001000);

        // clr with en high, then clr with en low.
        step(0, 1, 1, 24'h001000);
        chk("t4_clr_valid", {31'h0, vld_a}, 32'h0);
        for (int i = 0; i < 7; i++) step(0, 0, 1, 24'h001000);
        step(0, 1, 0, 24'h001000);
        chk("t4_clr_en0_acc", {16'h0, acc_a}, 32'h0);
        for (int i = 0; i < 7; i++) step(0, 0, 1, 24'h000777);

        // rst (with clr) during a carry pulse.
        step(0, 1, 1, 24'h0);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            step(0, 0, 1, 24'h001000);
            seen = cy_a;
        end
        chk("t5_carry_seen", {31'h0, seen}, 32'h1);
        step(1, 1, 1, 24'hFFFFFF);
        chk("t5_rst_out", {14'h0, vld_a, cy_a, acc_a}, 32'h0);
        step(0, 0, 0, 24'h0);

        // Randomised controls and data.
        for (int i = 0; i < 10000; i++) begin
            logic [23:0] xv;
            xv = 24'($urandom);
            if ($urandom_range(0, 7) == 0) xv = 24'hFFFFFF;
            step(($urandom_range(0, 999) == 0), ($urandom_range(0, 299) == 0),
                 ($urandom_range(0, 3) != 0), xv);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
